// File: rtl/game_palette_mapper.sv
// game_palette_mapper: snapshots the game state on frame_start, scans every ddaver cell and
// bullet through run-time programmable palettes (one object per cycle) into shadow registers,
// then commits all colours and positions to the outputs on a single edge.
// Optional feature: define GAME_PALETTE_BLINK_EN to enable per-state ddaver blinking.
module game_palette_mapper #(
  parameter int unsigned DD_ROWS        = 5,
  parameter int unsigned DD_COLS        = 6,
  parameter int unsigned NUM_BULLETS    = 3,
  parameter int unsigned DD_STATE_W     = 3,
  parameter int unsigned BB_STATE_W     = 2,
  parameter int unsigned POS_W          = 4,
  parameter int unsigned COLOR_W        = 12,
  parameter int unsigned BLINK_DIV_LOG2 = 3
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   frame_start,
  input  logic [POS_W-1:0]                       block_pos,
  input  logic [DD_ROWS*DD_COLS*DD_STATE_W-1:0]  dd_state,
  input  logic [NUM_BULLETS*BB_STATE_W-1:0]      bull_state,
  input  logic [NUM_BULLETS*POS_W-1:0]           bull_x,
  input  logic [NUM_BULLETS*POS_W-1:0]           bull_y,
  input  logic                                   pal_we,
  input  logic                                   pal_sel,
  input  logic [DD_STATE_W-1:0]                  pal_addr,
  input  logic [COLOR_W-1:0]                     pal_wdata,
  input  logic [(1<<DD_STATE_W)-1:0]             blink_mask,
  output logic [POS_W-1:0]                       block_pos_o,
  output logic [DD_ROWS*DD_COLS*COLOR_W-1:0]     dd_color,
  output logic [NUM_BULLETS*COLOR_W-1:0]         bb_color,
  output logic [NUM_BULLETS*POS_W-1:0]           bb_x,
  output logic [NUM_BULLETS*POS_W-1:0]           bb_y,
  output logic                                   busy,
  output logic                                   frame_done,
  output logic                                   overrun
);

  localparam int unsigned NumCells = DD_ROWS * DD_COLS;
  localparam int unsigned DdDepth  = 1 << DD_STATE_W;
  localparam int unsigned BbDepth  = 1 << BB_STATE_W;
  localparam int unsigned MaxObj   = (NumCells > NUM_BULLETS) ? NumCells : NUM_BULLETS;
  localparam int unsigned IdxW     = (MaxObj > 1) ? $clog2(MaxObj) : 1;
  localparam logic [IdxW-1:0] LastCell = IdxW'(NumCells - 1);
  localparam logic [IdxW-1:0] LastBull = IdxW'(NUM_BULLETS - 1);

  typedef enum logic [1:0] {StIdle, StScanDd, StScanBb, StCommit} state_e;

  function automatic logic [COLOR_W-1:0] dd_pal_init(input int i);
    logic [11:0] c;
    case (i)
      1:       c = 12'hF0F;
      2:       c = 12'hFF0;
      3:       c = 12'h0FF;
      4:       c = 12'h00F;
      5:       c = 12'hF00;
      6:       c = 12'h0F0;
      default: c = 12'h000;
    endcase
    return COLOR_W'(c);
  endfunction

  function automatic logic [COLOR_W-1:0] bb_pal_init(input int i);
    logic [11:0] c;
    case (i)
      1:       c = 12'h00F;
      2:       c = 12'hF00;
      3:       c = 12'h0F0;
      default: c = 12'h000;
    endcase
    return COLOR_W'(c);
  endfunction

  state_e                  state_q, state_d;
  logic [IdxW-1:0]         idx_q, idx_d;
  logic                    overrun_q;

  logic [COLOR_W-1:0]      dd_pal_q [DdDepth];
  logic [COLOR_W-1:0]      bb_pal_q [BbDepth];

  logic [POS_W-1:0]                  snap_blk_q;
  logic [NumCells*DD_STATE_W-1:0]    snap_dd_q;
  logic [NUM_BULLETS*BB_STATE_W-1:0] snap_bs_q;
  logic [NUM_BULLETS*POS_W-1:0]      snap_bx_q, snap_by_q;

  logic [NumCells*COLOR_W-1:0]       sh_dd_q;
  logic [NUM_BULLETS*COLOR_W-1:0]    sh_bc_q;
  logic [NUM_BULLETS*POS_W-1:0]      sh_bx_q, sh_by_q;

  logic [POS_W-1:0]                  out_blk_q;
  logic [NumCells*COLOR_W-1:0]       out_dd_q;
  logic [NUM_BULLETS*COLOR_W-1:0]    out_bc_q;
  logic [NUM_BULLETS*POS_W-1:0]      out_bx_q, out_by_q;

  logic [DD_STATE_W-1:0]   dd_code;
  logic [BB_STATE_W-1:0]   bb_code;
  logic                    blink_off;
  logic                    start_ok;

  assign start_ok = (state_q == StIdle) && frame_start;

  // State register and scan index
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      idx_q     <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      overrun_q <= frame_start && (state_q != StIdle);
    end
  end

  // Next-state: walk cells, then bullets, then a single commit cycle
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      StIdle: begin
        if (frame_start) begin
          state_d = StScanDd;
          idx_d   = '0;
        end
      end
      StScanDd: begin
        if (idx_q == LastCell) begin
          state_d = StScanBb;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      StScanBb: begin
        if (idx_q == LastBull) state_d = StCommit;
        else                   idx_d   = idx_q + 1'b1;
      end
      StCommit: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Palette storage; writes land in any state and are seen by the next lookup
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DdDepth; i++) dd_pal_q[i] <= dd_pal_init(i);
      for (int i = 0; i < BbDepth; i++) bb_pal_q[i] <= bb_pal_init(i);
    end else if (pal_we) begin
      if (pal_sel) bb_pal_q[pal_addr[BB_STATE_W-1:0]] <= pal_wdata;
      else         dd_pal_q[pal_addr]                 <= pal_wdata;
    end
  end

  // Current object's palette index from the snapshot
  always_comb begin
    dd_code = snap_dd_q[int'(idx_q)*DD_STATE_W +: DD_STATE_W];
    bb_code = snap_bs_q[int'(idx_q)*BB_STATE_W +: BB_STATE_W];
  end

`ifdef GAME_PALETTE_BLINK_EN
  logic [BLINK_DIV_LOG2:0] blink_q;

  // Committed-frame counter; its MSB is the blink phase
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   blink_q <= '0;
    else if (state_q == StCommit) blink_q <= blink_q + 1'b1;
  end

  assign blink_off = blink_q[BLINK_DIV_LOG2] & blink_mask[dd_code];
`else
  logic unused_blink_mask;
  assign unused_blink_mask = ^blink_mask;
  assign blink_off         = 1'b0;
`endif

  // Snapshot capture on an accepted frame_start only
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap_blk_q <= '0;
      snap_dd_q  <= '0;
      snap_bs_q  <= '0;
      snap_bx_q  <= '0;
      snap_by_q  <= '0;
    end else if (start_ok) begin
      snap_blk_q <= block_pos;
      snap_dd_q  <= dd_state;
      snap_bs_q  <= bull_state;
      snap_bx_q  <= bull_x;
      snap_by_q  <= bull_y;
    end
  end

  // Shadow fill, one object per cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_dd_q <= '0;
      sh_bc_q <= '0;
      sh_bx_q <= '0;
      sh_by_q <= '0;
    end else if (state_q == StScanDd) begin
      sh_dd_q[int'(idx_q)*COLOR_W +: COLOR_W] <= blink_off ? '0 : dd_pal_q[dd_code];
    end else if (state_q == StScanBb) begin
      sh_bc_q[int'(idx_q)*COLOR_W +: COLOR_W] <= bb_pal_q[bb_code];
      sh_bx_q[int'(idx_q)*POS_W +: POS_W]     <= snap_bx_q[int'(idx_q)*POS_W +: POS_W];
      sh_by_q[int'(idx_q)*POS_W +: POS_W]     <= snap_by_q[int'(idx_q)*POS_W +: POS_W];
    end
  end

  // Atomic commit of the whole frame to the outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_blk_q <= '0;
      out_dd_q  <= '0;
      out_bc_q  <= '0;
      out_bx_q  <= '0;
      out_by_q  <= '0;
    end else if (state_q == StCommit) begin
      out_blk_q <= snap_blk_q;
      out_dd_q  <= sh_dd_q;
      out_bc_q  <= sh_bc_q;
      out_bx_q  <= sh_bx_q;
      out_by_q  <= sh_by_q;
    end
  end

  assign block_pos_o = out_blk_q;
  assign dd_color    = out_dd_q;
  assign bb_color    = out_bc_q;
  assign bb_x        = out_bx_q;
  assign bb_y        = out_by_q;
  assign busy        = (state_q != StIdle);
  assign frame_done  = (state_q == StCommit);
  assign overrun     = overrun_q;

endmodule
